register_file: RTL and testbench

ARMv4 integer register file: sixteen architectural registers R0–R15 with two combinational read ports (Rn, Rm) and one synchronous write port (Rd). R0–R14 are storage. R15 reads return the externally supplied PC value (R15_DATA) instead of stored state. Sits in the datapath between instruction decode and the ALU/shifter; the write-back stage drives the write port.

---
 rtl/register_file.sv | 61 ++++++
 tb/tb_register_file.sv | 128 ++++++++++++
 2 files changed

// File: rtl/register_file.sv
// ARMv4 integer register file: R0-R14 stored in flops, R15 reads return the
// externally supplied PC value. Two combinational read ports, one write port.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            ADDRS_RN,
  input  logic [3:0]            ADDRS_RM,
  input  logic [3:0]            ADDRS_RD,
  input  logic [DATA_WIDTH-1:0] WRT_DATA,
  input  logic [DATA_WIDTH-1:0] R15_DATA,
  input  logic                  WRT_ENA,
  output logic [DATA_WIDTH-1:0] RN_DATA,
  output logic [DATA_WIDTH-1:0] RM_DATA
);

  // The highest address is the PC; it has no storage behind it.
  localparam int         NUM_STORED = NUM_REGS - 1;
  localparam logic [3:0] PC_ADDR    = 4'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] regs_q [NUM_STORED];
  logic [DATA_WIDTH-1:0] regs_d [NUM_STORED];

  // Next-state: only the addressed stored register takes the write data;
  // writes aimed at the PC address are dropped.
  always_comb begin
    for (int i = 0; i < NUM_STORED; i++) begin
      regs_d[i] = regs_q[i];
      if (WRT_ENA && (ADDRS_RD != PC_ADDR) && (ADDRS_RD == 4'(i))) begin
        regs_d[i] = WRT_DATA;
      end
    end
  end

  // Storage update; the asynchronous reset clears every stored register and
  // overrides any write on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_STORED; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STORED; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: no write bypass, PC address returns the live PC value.
  always_comb begin
    RN_DATA = R15_DATA;
    RM_DATA = R15_DATA;
    for (int i = 0; i < NUM_STORED; i++) begin
      if (ADDRS_RN == 4'(i)) RN_DATA = regs_q[i];
      if (ADDRS_RM == 4'(i)) RM_DATA = regs_q[i];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        CLK;
  logic        RST;
  logic [3:0]  ADDRS_RN;
  logic [3:0]  ADDRS_RM;
  logic [3:0]  ADDRS_RD;
  logic [31:0] WRT_DATA;
  logic [31:0] R15_DATA;
  logic        WRT_ENA;
  logic [31:0] RN_DATA;
  logic [31:0] RM_DATA;

  int n_cmp = 0;
  int n_err = 0;

  register_file #(.DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .CLK(CLK), .RST(RST),
    .ADDRS_RN(ADDRS_RN), .ADDRS_RM(ADDRS_RM), .ADDRS_RD(ADDRS_RD),
    .WRT_DATA(WRT_DATA), .R15_DATA(R15_DATA), .WRT_ENA(WRT_ENA),
    .RN_DATA(RN_DATA), .RM_DATA(RM_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b0; ADDRS_RN = '0; ADDRS_RM = '0; ADDRS_RD = '0;
    WRT_DATA = '0; R15_DATA = '0; WRT_ENA = 1'b0;

    // Step 1: reset for one clock, then every stored register reads 0.
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int a = 0; a < 15; a++) begin
      ADDRS_RN = 4'(a); ADDRS_RM = 4'(a);
      #1;
      chk($sformatf("reset_rn_%0d", a), RN_DATA, 32'h0);
      chk($sformatf("reset_rm_%0d", a), RM_DATA, 32'h0);
    end

    // Step 2: write a to each address 0..15, then read back.
    for (int a = 0; a < 16; a++) begin
      @(negedge CLK);
      ADDRS_RD = 4'(a); WRT_DATA = 32'(a); R15_DATA = 32'(a); WRT_ENA = 1'b1;
    end
    @(negedge CLK);
    WRT_ENA = 1'b0;
    for (int a = 0; a < 16; a++) begin
      ADDRS_RN = 4'(a); ADDRS_RM = 4'(15 - a);
      #1;
      chk($sformatf("fill_rn_%0d", a), RN_DATA, 32'(a));
      chk($sformatf("fill_rm_%0d", 15 - a), RM_DATA, 32'(15 - a));
    end

    // Step 3: write with enable low changes nothing.
    @(negedge CLK);
    ADDRS_RD = 4'd3; WRT_DATA = 32'hDEADBEEF; WRT_ENA = 1'b0;
    ADDRS_RN = 4'd3; ADDRS_RM = 4'd3;
    @(posedge CLK); #1;
    chk("wena0_r3", RN_DATA, 32'd3);

    // Step 4: read and write R5 in the same cycle, no bypass.
    @(negedge CLK);
    ADDRS_RN = 4'd5; ADDRS_RM = 4'd5;
    ADDRS_RD = 4'd5; WRT_DATA = 32'h12345678; WRT_ENA = 1'b1;
    #1;
    chk("r5_before_rn", RN_DATA, 32'd5);
    chk("r5_before_rm", RM_DATA, 32'd5);
    @(posedge CLK); #1;
    chk("r5_after_rn", RN_DATA, 32'h12345678);
    chk("r5_after_rm", RM_DATA, 32'h12345678);
    @(negedge CLK);
    WRT_ENA = 1'b0;

    // Step 5: R15 follows R15_DATA combinationally; writes to 15 ignored.
    ADDRS_RN = 4'd15; ADDRS_RM = 4'd14;
    R15_DATA = 32'h8;
    #1;
    chk("r15_pc8", RN_DATA, 32'h8);
    R15_DATA = 32'h100;
    #1;
    chk("r15_pc100", RN_DATA, 32'h100);
    @(negedge CLK);
    ADDRS_RD = 4'd15; WRT_DATA = 32'hFFFFFFFF; WRT_ENA = 1'b1;
    @(posedge CLK); #1;
    chk("r15_write_ignored", RN_DATA, 32'h100);
    chk("r14_untouched", RM_DATA, 32'd14);
    @(negedge CLK);
    WRT_ENA = 1'b0;

    // Step 6: asynchronous reset clears storage between edges.
    ADDRS_RN = 4'd5; ADDRS_RM = 4'd14;
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_r5", RN_DATA, 32'h0);
    chk("async_rst_r14", RM_DATA, 32'h0);
    ADDRS_RN = 4'd15;
    #1;
    chk("async_rst_r15_path", RN_DATA, 32'h100);
    // Writes are blocked while reset is held.
    ADDRS_RD = 4'd7; WRT_DATA = 32'hAAAA5555; WRT_ENA = 1'b1; ADDRS_RN = 4'd7;
    @(posedge CLK); #1;
    chk("rst_blocks_write", RN_DATA, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_release_no_write", RN_DATA, 32'h0);
    @(posedge CLK); #1;
    chk("first_write_after_rst", RN_DATA, 32'hAAAA5555);
    @(negedge CLK);
    WRT_ENA = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
